// File: rtl/lzc_packed.sv
// Two-stage multi-precision leading-zero counter (1/2/4 lanes); results two edges after the input is presented.
// Backpressure: out_ready low freezes S2; S1 fills once, then in_ready drops until S2 moves.
module lzc_packed #(
  parameter int DATA_W = 106,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_mode,
  output logic [CNT_W-1:0]  shtamt0,
  output logic [CNT_W-1:0]  shtamt1,
  output logic [CNT_W-1:0]  shtamt2,
  output logic [CNT_W-1:0]  shtamt3,
  output logic [3:0]        zero
);

  function automatic logic [5:0] lzc54(input logic [53:0] v);
    logic [5:0] c;
    c = 6'd54;
    for (int i = 0; i < 54; i++) begin
      if (v[i]) c = 6'(53 - i);
    end
    return c;
  endfunction

  // Each lane is left-justified into 107 bits with a 1 right below its LSB,
  // so an all-zero lane counts to exactly its width; unused lanes count 0.
  logic [3:0][106:0] lane;
  logic [3:0]        lz_d;
  logic [3:0][5:0]   hi_cnt_d, lo_cnt_d;
  logic [3:0]        hi_z_d;

  always_comb begin
    lane = {4{1'b1, 106'b0}};
    lz_d = 4'b0000;
    case (in_mode)
      2'b01: begin
        lane[0] = {in_data[21:0],   1'b1, 84'b0};
        lane[1] = {in_data[49:28],  1'b1, 84'b0};
        lane[2] = {in_data[77:56],  1'b1, 84'b0};
        lane[3] = {in_data[105:84], 1'b1, 84'b0};
        lz_d    = {~|in_data[105:84], ~|in_data[77:56], ~|in_data[49:28], ~|in_data[21:0]};
      end
      2'b10: begin
        lane[0] = {in_data[47:0],   1'b1, 58'b0};
        lane[1] = {in_data[105:58], 1'b1, 58'b0};
        lz_d    = {2'b00, ~|in_data[105:58], ~|in_data[47:0]};
      end
      default: begin
        lane[0] = {in_data, 1'b1};
        lz_d    = {3'b000, ~|in_data};
      end
    endcase
    for (int n = 0; n < 4; n++) begin
      hi_cnt_d[n] = lzc54({lane[n][106:54], 1'b1});
      hi_z_d[n]   = ~|lane[n][106:54];
      lo_cnt_d[n] = lzc54(lane[n][53:0]);
    end
  end

  logic              v1_q, v2_q;
  logic [DATA_W-1:0] data1_q;
  logic [1:0]        mode1_q;
  logic [3:0][5:0]   hi_cnt_q, lo_cnt_q;
  logic [3:0]        hi_z_q, lz_q;
  logic [3:0][CNT_W-1:0] cnt_d, cnt_q;
  logic [DATA_W-1:0] data2_q;
  logic [1:0]        mode2_q;
  logic [3:0]        zero_q;
  logic              s2_adv, s1_load;

  assign s2_adv   = !v2_q || out_ready;
  assign in_ready = !v1_q || s2_adv;
  assign s1_load  = in_valid && in_ready;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      cnt_d[n] = hi_z_q[n] ? (7'd53 + {1'b0, lo_cnt_q[n]}) : {1'b0, hi_cnt_q[n]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      data1_q  <= '0;
      mode1_q  <= '0;
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
      hi_z_q   <= '0;
      lz_q     <= '0;
    end else begin
      if (in_ready) v1_q <= in_valid;
      if (s1_load) begin
        data1_q  <= in_data;
        mode1_q  <= in_mode;
        hi_cnt_q <= hi_cnt_d;
        lo_cnt_q <= lo_cnt_d;
        hi_z_q   <= hi_z_d;
        lz_q     <= lz_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      data2_q <= '0;
      mode2_q <= '0;
      cnt_q   <= '0;
      zero_q  <= '0;
    end else if (s2_adv) begin
      v2_q <= v1_q;
      if (v1_q) begin
        data2_q <= data1_q;
        mode2_q <= mode1_q;
        cnt_q   <= cnt_d;
        zero_q  <= lz_q;
      end
    end
  end

  assign out_valid = v2_q;
  assign out_data  = data2_q;
  assign out_mode  = mode2_q;
  assign shtamt0   = cnt_q[0];
  assign shtamt1   = cnt_q[1];
  assign shtamt2   = cnt_q[2];
  assign shtamt3   = cnt_q[3];
  assign zero      = zero_q;

endmodule

// File: tb/tb_lzc_packed.sv
// Directed bench for lzc_packed: lane maps, all-zero lanes, stall/stream ordering, async reset.
module tb_lzc_packed;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [105:0] in_data, out_data;
  logic [1:0]   in_mode, out_mode;
  logic [6:0]   shtamt0, shtamt1, shtamt2, shtamt3;
  logic [3:0]   zero;

  int n_chk  = 0;
  int n_fail = 0;

  lzc_packed dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .shtamt0(shtamt0), .shtamt1(shtamt1), .shtamt2(shtamt2), .shtamt3(shtamt3),
    .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input logic [105:0] d, input logic [1:0] m,
                         input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2,
                         input logic [6:0] e3, input logic [3:0] ez);
    in_valid  = 1'b1;
    in_data   = d;
    in_mode   = m;
    out_ready = 1'b1;
    #1;
    check({tag, ".in_ready"}, 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    in_data  = '1;
    check({tag, ".early"}, 128'(out_valid), 128'd0);
    step();
    check({tag, ".out_valid"}, 128'(out_valid), 128'd1);
    check({tag, ".out_data"}, 128'(out_data), 128'(d));
    check({tag, ".out_mode"}, 128'(out_mode), 128'(m));
    check({tag, ".shtamt0"}, 128'(shtamt0), 128'(e0));
    check({tag, ".shtamt1"}, 128'(shtamt1), 128'(e1));
    check({tag, ".shtamt2"}, 128'(shtamt2), 128'(e2));
    check({tag, ".shtamt3"}, 128'(shtamt3), 128'(e3));
    check({tag, ".zero"}, 128'(zero), 128'(ez));
    step();
    check({tag, ".drained"}, 128'(out_valid), 128'd0);
  endtask

  logic [105:0] d;
  logic [105:0] words [8];
  int           acc, pop, cyc;
  bit           saw_block, held_vld;
  logic [105:0] held_data;
  logic [6:0]   held_cnt;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 2'b00; out_ready = 1'b1;
    #1;
    check("reset.out_valid", 128'(out_valid), 128'd0);
    check("reset.out_data", 128'(out_data), 128'd0);
    check("reset.shtamt0", 128'(shtamt0), 128'd0);
    check("reset.zero", 128'(zero), 128'd0);
    #12 rst_n = 1'b1;
    step();
    check("reset.in_ready", 128'(in_ready), 128'd1);

    d = '0; d[100] = 1'b1;
    run_vec("m00_bit100", d, 2'b00, 7'd5, 7'd0, 7'd0, 7'd0, 4'b0000);

    d = '1;
    d[21:0] = 22'h000001; d[49:28] = 22'h200000; d[77:56] = 22'h0; d[105:84] = 22'h000400;
    run_vec("m01_lanes", d, 2'b01, 7'd21, 7'd0, 7'd22, 7'd11, 4'b0100);

    d = '1;
    d[47:0] = 48'h000000000100; d[105:58] = 48'h800000000000;
    run_vec("m10_lanes", d, 2'b10, 7'd39, 7'd0, 7'd0, 7'd0, 4'b0000);

    run_vec("m00_zero", 106'd0, 2'b00, 7'd106, 7'd0, 7'd0, 7'd0, 4'b0001);
    run_vec("m01_zero", 106'd0, 2'b01, 7'd22, 7'd22, 7'd22, 7'd22, 4'b1111);
    run_vec("m11_msb", {1'b1, 105'd0}, 2'b11, 7'd0, 7'd0, 7'd0, 7'd0, 4'b0000);
    run_vec("m10_zero", 106'd0, 2'b10, 7'd48, 7'd48, 7'd0, 7'd0, 4'b0011);

    // Stream of 8 single-lane words, word i has its top set bit at 100-7i.
    for (int i = 0; i < 8; i++) begin
      words[i] = '0;
      words[i][100 - 7*i] = 1'b1;
    end
    acc = 0; pop = 0; saw_block = 1'b0; held_vld = 1'b0;
    in_mode = 2'b00;
    for (cyc = 0; cyc < 40 && pop < 8; cyc++) begin
      in_valid  = (acc < 8);
      in_data   = (acc < 8) ? words[acc] : '1;
      out_ready = !(cyc >= 3 && cyc <= 7);
      #1;
      if (held_vld) begin
        check("stall.data_hold", 128'(out_data), 128'(held_data));
        check("stall.cnt_hold", 128'(shtamt0), 128'(held_cnt));
      end
      if (cyc >= 8) check("stream.no_gap", 128'(out_valid), 128'd1);
      if (in_valid && !in_ready) begin
        saw_block = 1'b1;
        check("stall.in_flight", 128'(acc - pop), 128'd2);
      end
      held_vld  = out_valid && !out_ready;
      held_data = out_data;
      held_cnt  = shtamt0;
      if (out_valid && out_ready) begin
        check("stream.data", 128'(out_data), 128'(words[pop]));
        check("stream.cnt", 128'(shtamt0), 128'(5 + 7*pop));
        pop++;
      end
      if (in_valid && in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    check("stream.all_out", 128'(pop), 128'd8);
    check("stream.blocked", 128'(saw_block), 128'd1);
    check("stream.empty", 128'(out_valid), 128'd0);

    // Fill both stages, then reset mid-cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1; in_mode = 2'b00; in_data = words[0];
    step();
    in_data = words[1];
    step();
    in_valid = 1'b0;
    check("prerst.full_vld", 128'(out_valid), 128'd1);
    check("prerst.in_ready", 128'(in_ready), 128'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst.out_valid", 128'(out_valid), 128'd0);
    check("rst.out_data", 128'(out_data), 128'd0);
    check("rst.shtamt0", 128'(shtamt0), 128'd0);
    check("rst.out_mode", 128'(out_mode), 128'd0);
    check("rst.in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("postrst.stale", 128'(out_valid), 128'd0);
    d = '0; d[60] = 1'b1;
    run_vec("postrst_word", d, 2'b00, 7'd45, 7'd0, 7'd0, 7'd0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step();
      check("postrst.idle", 128'(out_valid), 128'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
